// File: rtl/parity_stream_checker.sv
// One-stage registered parity checker/regenerator with run-time even/odd selection.
// Also keeps saturating beat/error statistics and a sticky error flag.
module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_parity,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  beat_count,
    output logic              err_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_parity;
    logic              r_out_err;
    logic [CNT_W-1:0]  r_err_count;
    logic [CNT_W-1:0]  r_beat_count;
    logic              r_err_sticky;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_data_xor;
    logic              w_gen_parity;
    logic              w_word_err;
    logic [CNT_W-1:0]  w_err_count_next;
    logic [CNT_W-1:0]  w_beat_count_next;
    logic              w_err_sticky_next;

    assign w_in_ready   = !r_out_valid || out_ready;
    assign w_accept     = in_valid && w_in_ready;
    assign w_data_xor   = ^in_data;
    assign w_gen_parity = w_data_xor ^ odd_mode;
    assign w_word_err   = w_data_xor ^ in_parity ^ odd_mode;

    // A clear coinciding with an accept restarts the statistics from this beat.
    always_comb begin
        w_err_count_next  = r_err_count;
        w_beat_count_next = r_beat_count;
        w_err_sticky_next = r_err_sticky;
        if (clr_stats) begin
            w_beat_count_next = CNT_W'(w_accept);
            w_err_count_next  = CNT_W'(w_accept && w_word_err);
            w_err_sticky_next = w_accept && w_word_err;
        end else if (w_accept) begin
            if (r_beat_count != CNT_MAX) begin
                w_beat_count_next = r_beat_count + CNT_W'(1);
            end
            if (w_word_err && (r_err_count != CNT_MAX)) begin
                w_err_count_next = r_err_count + CNT_W'(1);
            end
            if (w_word_err) begin
                w_err_sticky_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_parity <= 1'b0;
            r_out_err    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= in_data;
            r_out_parity <= w_gen_parity;
            r_out_err    <= w_word_err;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count  <= '0;
            r_beat_count <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_err_count  <= w_err_count_next;
            r_beat_count <= w_beat_count_next;
            r_err_sticky <= w_err_sticky_next;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_parity = r_out_parity;
    assign out_err    = r_out_err;
    assign err_count  = r_err_count;
    assign beat_count = r_beat_count;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench: default-width instance for data-path checks, CNT_W=2 instance for saturation.
module tb_parity_stream_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance (DATA_W=8, CNT_W=16)
    logic        odd_mode, clr_stats, in_valid, in_parity, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_parity, out_err, err_sticky;
    logic [7:0]  out_data;
    logic [15:0] err_count, beat_count;

    // Saturation instance (DATA_W=8, CNT_W=2)
    logic        b_odd_mode, b_clr_stats, b_in_valid, b_in_parity, b_out_ready;
    logic [7:0]  b_in_data;
    logic        b_in_ready, b_out_valid, b_out_parity, b_out_err, b_err_sticky;
    logic [7:0]  b_out_data;
    logic [1:0]  b_err_count, b_beat_count;

    parity_stream_checker #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .out_err(out_err), .err_count(err_count),
        .beat_count(beat_count), .err_sticky(err_sticky)
    );

    parity_stream_checker #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .odd_mode(b_odd_mode), .clr_stats(b_clr_stats),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_parity(b_in_parity),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_parity(b_out_parity), .out_err(b_out_err), .err_count(b_err_count),
        .beat_count(b_beat_count), .err_sticky(b_err_sticky)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        odd_mode = 0; clr_stats = 0; in_valid = 0; in_parity = 0; in_data = '0; out_ready = 1;
        b_odd_mode = 0; b_clr_stats = 0; b_in_valid = 0; b_in_parity = 0; b_in_data = '0; b_out_ready = 1;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_parity !== 1'b0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_datapath: valid=%b data=%h par=%b err=%b, required all 0", out_valid, out_data, out_parity, out_err);
        end
        checks++;
        if (err_count !== 16'd0 || beat_count !== 16'd0 || err_sticky !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_stats: err=%0d beat=%0d sticky=%b in_ready=%b, required 0 0 0 1", err_count, beat_count, err_sticky, in_ready);
        end
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_even_ok;
        in_valid = 1; in_data = 8'hA5; in_parity = 0; odd_mode = 0;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_err !== 1'b0 || out_parity !== 1'b0
            || beat_count !== 16'd1 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL even_ok: valid=%b data=%h err=%b par=%b beat=%0d errc=%0d, required 1 a5 0 0 1 0",
                     out_valid, out_data, out_err, out_parity, beat_count, err_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            failures++;
            $display("FAIL drain_idle: valid=%b data=%h, required 0 a5", out_valid, out_data);
        end
        $display("even A5 beat: err=%b par=%b", out_err, out_parity);
    endtask

    task automatic test_error_and_mode;
        in_valid = 1; in_data = 8'h07; in_parity = 0; odd_mode = 0;
        tick();
        checks++;
        if (out_err !== 1'b1 || out_parity !== 1'b1 || err_count !== 16'd1 || err_sticky !== 1'b1 || beat_count !== 16'd2) begin
            failures++;
            $display("FAIL even_err: err=%b par=%b errc=%0d sticky=%b beat=%0d, required 1 1 1 1 2",
                     out_err, out_parity, err_count, err_sticky, beat_count);
        end
        odd_mode = 1;
        tick();
        in_valid = 0; odd_mode = 0;
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_parity !== 1'b0 || err_count !== 16'd1
            || err_sticky !== 1'b1 || beat_count !== 16'd3) begin
            failures++;
            $display("FAIL odd_ok: valid=%b err=%b par=%b errc=%0d sticky=%b beat=%0d, required 1 0 0 1 1 3",
                     out_valid, out_err, out_parity, err_count, err_sticky, beat_count);
        end
        tick();
        $display("07 beats: even err then odd ok");
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        in_valid = 1; in_data = 8'h3C; in_parity = 0;
        tick();
        in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h3C || beat_count !== 16'd4) begin
                failures++;
                $display("FAIL stall_%0d: in_ready=%b valid=%b data=%h beat=%0d, required 0 1 3c 4",
                         i, in_ready, out_valid, out_data, beat_count);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_comb: in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || out_err !== 1'b0 || beat_count !== 16'd5) begin
            failures++;
            $display("FAIL after_stall: valid=%b data=%h err=%b beat=%0d, required 1 ff 0 5",
                     out_valid, out_data, out_err, beat_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || beat_count !== 16'd5) begin
            failures++;
            $display("FAIL post_drain: valid=%b beat=%0d, required 0 5", out_valid, beat_count);
        end
        $display("backpressure: 3c held 5 cycles, ff delivered");
    endtask

    task automatic test_clear_idle;
        clr_stats = 1;
        tick();
        clr_stats = 0;
        checks++;
        if (err_count !== 16'd0 || beat_count !== 16'd0 || err_sticky !== 1'b0 || out_data !== 8'hFF) begin
            failures++;
            $display("FAIL clear_idle: errc=%0d beat=%0d sticky=%b data=%h, required 0 0 0 ff",
                     err_count, beat_count, err_sticky, out_data);
        end
        $display("clear without accept");
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [10];
        for (int i = 0; i < 10; i++) words[i] = 8'(i * 37 + 5);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_data = words[i]; in_parity = ^words[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== words[i] || out_err !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d: valid=%b data=%h err=%b in_ready=%b, required 1 %h 0 1",
                         i, out_valid, out_data, out_err, in_ready, words[i]);
            end
        end
        in_valid = 0;
        checks++;
        if (beat_count !== 16'd10 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL b2b_count: beat=%0d errc=%0d, required 10 0", beat_count, err_count);
        end
        tick();
        $display("back-to-back: 10 words streamed");
    endtask

    task automatic test_saturation;
        b_in_valid = 1; b_in_data = 8'h07; b_in_parity = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (b_err_count !== 2'((i > 3) ? 3 : i) || b_beat_count !== 2'((i > 3) ? 3 : i) || b_out_err !== 1'b1) begin
                failures++;
                $display("FAIL sat_%0d: errc=%0d beat=%0d err=%b, required %0d %0d 1",
                         i, b_err_count, b_beat_count, b_out_err, (i > 3) ? 3 : i, (i > 3) ? 3 : i);
            end
        end
        b_clr_stats = 1;
        tick();
        checks++;
        if (b_err_count !== 2'd1 || b_beat_count !== 2'd1 || b_err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL clear_accept: errc=%0d beat=%0d sticky=%b, required 1 1 1", b_err_count, b_beat_count, b_err_sticky);
        end
        b_in_data = 8'h03;
        tick();
        b_in_valid = 0; b_clr_stats = 0;
        checks++;
        if (b_err_count !== 2'd0 || b_beat_count !== 2'd1 || b_err_sticky !== 1'b0 || b_out_err !== 1'b0) begin
            failures++;
            $display("FAIL clear_accept_ok: errc=%0d beat=%0d sticky=%b err=%b, required 0 1 0 0",
                     b_err_count, b_beat_count, b_err_sticky, b_out_err);
        end
        $display("saturation at CNT_W=2 done");
    endtask

    task automatic test_reset_mid_stall;
        out_ready = 0;
        in_valid = 1; in_data = 8'h01; in_parity = 0;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || err_sticky !== 1'b1 || beat_count !== 16'd11) begin
            failures++;
            $display("FAIL pre_reset: valid=%b sticky=%b beat=%0d, required 1 1 11", out_valid, err_sticky, beat_count);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || beat_count !== 16'd0 || err_count !== 16'd0 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b beat=%0d errc=%0d sticky=%b, required 0 0 0 0",
                     out_valid, beat_count, err_count, err_sticky);
        end
        tick();
        rst_n = 1; out_ready = 1;
        tick();
        $display("async reset mid-stall");
    endtask

    initial begin
        test_reset();
        test_even_ok();
        test_error_and_mode();
        test_backpressure();
        test_clear_idle();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
